// File: rtl/multicycle_control_hs.sv
// multicycle_control_hs: TSC-ISA multi-cycle controller with handshaked
// memory, access watchdog and parameterised retire counter.
module multicycle_control_hs #(
  parameter int NUM_INST_W  = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            opcode,
  input  logic [5:0]            func,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  read_m,
  output logic                  write_m,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic [1:0]            reg_dst,
  output logic [1:0]            reg_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [3:0]            alu_op,
  output logic                  open_port,
  output logic                  halted,
  output logic                  mem_error,
  output logic                  inst_done,
  output logic [NUM_INST_W-1:0] num_inst
);
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST =
    TIMEOUT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t               state, state_nx;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_nx;
  logic                 set_halt, set_err;
  logic                 is_r, r_alu, i_alu, is_lwd, is_swd, is_br;
  logic                 is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt;

  assign is_r   = opcode == OP_R;
  assign r_alu  = is_r && func < 6'd8;
  assign i_alu  = opcode inside {OP_ADI, OP_ORI, OP_LHI};
  assign is_lwd = opcode == OP_LWD;
  assign is_swd = opcode == OP_SWD;
  assign is_br  = opcode <= OP_BLZ;
  assign is_jmp = opcode == OP_JMP;
  assign is_jal = opcode == OP_JAL;
  assign is_jpr = is_r && func == FN_JPR;
  assign is_jrl = is_r && func == FN_JRL;
  assign is_wwd = is_r && func == FN_WWD;
  assign is_hlt = is_r && func == FN_HLT;

  always_comb begin
    state_nx      = state;
    wait_nx       = wait_cnt;
    set_halt      = 1'b0;
    set_err       = 1'b0;
    mem_req       = 1'b0;
    read_m        = 1'b0;
    write_m       = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    reg_src       = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 4'd15;
    open_port     = 1'b0;
    inst_done     = 1'b0;
    if (!reset) begin
      unique case (state)
        S_IF: begin
          mem_req = 1'b1;
          read_m  = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = 4'd0;
            pc_write  = 1'b1;
            state_nx  = S_ID;
          end
        end
        S_ID: begin
          alu_src_b = 2'b10;
          alu_op    = 4'd0;
          inst_done = 1'b1;
          state_nx  = S_IF;
          unique case (1'b1)
            is_jmp: begin
              pc_src   = 2'b10;
              pc_write = 1'b1;
            end
            is_jal: begin
              reg_dst   = 2'b10;
              reg_src   = 2'b10;
              reg_write = 1'b1;
              pc_src    = 2'b10;
              pc_write  = 1'b1;
            end
            is_jpr: begin
              pc_src   = 2'b11;
              pc_write = 1'b1;
            end
            is_jrl: begin
              reg_dst   = 2'b10;
              reg_src   = 2'b10;
              reg_write = 1'b1;
              pc_src    = 2'b11;
              pc_write  = 1'b1;
            end
            is_hlt: begin
              set_halt = 1'b1;
              state_nx = S_HALT;
            end
            is_wwd: open_port = 1'b1;
            r_alu, i_alu, is_lwd, is_swd, is_br: begin
              inst_done = 1'b0;
              state_nx  = S_EX;
            end
            default: ;
          endcase
        end
        S_EX: begin
          alu_src_a = 1'b1;
          state_nx  = S_WB;
          unique case (1'b1)
            r_alu: alu_op = func[3:0];
            i_alu: begin
              alu_src_b = 2'b10;
              alu_op    = (opcode == OP_ADI) ? 4'd0 :
                          (opcode == OP_ORI) ? 4'd3 : 4'd8;
            end
            is_lwd, is_swd: begin
              alu_src_b = 2'b10;
              alu_op    = 4'd0;
              state_nx  = S_MEM;
            end
            is_br: begin
              pc_src        = 2'b01;
              pc_write_cond = 1'b1;
              alu_op        = 4'd9 + opcode;
              inst_done     = 1'b1;
              state_nx      = S_IF;
            end
            default: begin
              inst_done = 1'b1;
              state_nx  = S_IF;
            end
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          read_m  = is_lwd;
          write_m = is_swd;
          if (mem_ready) begin
            inst_done = !is_lwd;
            state_nx  = is_lwd ? S_WB : S_IF;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = r_alu ? 2'b01 : 2'b00;
          reg_src   = is_lwd ? 2'b01 : 2'b00;
          inst_done = 1'b1;
          state_nx  = S_IF;
        end
        default: ;
      endcase
      // Watchdog: a ready on the limit cycle still completes the access.
      if (mem_req && !mem_ready) begin
        if (wait_cnt == WAIT_LAST) begin
          state_nx = S_ERR;
          set_err  = 1'b1;
        end else begin
          wait_nx = wait_cnt + TIMEOUT_W'(1);
        end
      end
      if (state_nx != state &&
          (state_nx == S_IF || state_nx == S_MEM))
        wait_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IF;
      wait_cnt  <= '0;
      num_inst  <= '0;
      halted    <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (inst_done) num_inst <= num_inst + NUM_INST_W'(1);
      if (set_halt) halted <= 1'b1;
      if (set_err) mem_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_control_hs.sv
// Scoreboard bench for multicycle_control_hs: random TSC-ISA programs with
// random memory latencies, checked per retired instruction.
`timescale 1ns/1ps
module tb_multicycle_control_hs;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode;
  logic [5:0]    func;
  logic          mem_ready;
  logic          mem_req, read_m, write_m, iord, ir_write;
  logic          pc_write, pc_write_cond, reg_write, alu_src_a;
  logic [1:0]    pc_src, reg_dst, reg_src, alu_src_b;
  logic [3:0]    alu_op;
  logic          open_port, halted, mem_error, inst_done;
  logic [NW-1:0] num_inst;

  multicycle_control_hs #(
    .NUM_INST_W(NW), .MEM_TIMEOUT(15), .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func),
    .mem_ready(mem_ready), .mem_req(mem_req), .read_m(read_m),
    .write_m(write_m), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .reg_src(reg_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .open_port(open_port), .halted(halted),
    .mem_error(mem_error), .inst_done(inst_done),
    .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  typedef enum {
    C_RALU, C_ADI, C_ORI, C_LHI, C_LWD, C_SWD, C_BR,
    C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_NOP
  } cls_t;

  typedef struct {
    int cycles; int req; int rd; int wr; int irw; int pcw;
    int pcwc; int rw; int dst; int src; int op; int ex_op;
    int ex_b; int jsrc; int num;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] instr_q[$];
  int         lat_q[$];
  int         checks = 0;
  int         errors = 0;
  int         issued = 0;

  int a_cyc, a_req, a_rd, a_wr, a_irw, a_pcw, a_pcwc, a_rw;
  int a_dst, a_src, a_op, a_ex_op, a_ex_b, a_jsrc;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic cls_t cls(logic [3:0] o, logic [5:0] f);
    cls_t k;
    k = C_NOP;
    if (o == 4'd15) begin
      if (f < 6'd8) k = C_RALU;
      else if (f == 6'd25) k = C_JPR;
      else if (f == 6'd26) k = C_JRL;
      else if (f == 6'd28) k = C_WWD;
      else if (f == 6'd29) k = C_HLT;
    end else if (o <= 4'd3) k = C_BR;
    else if (o == 4'd4) k = C_ADI;
    else if (o == 4'd5) k = C_ORI;
    else if (o == 4'd6) k = C_LHI;
    else if (o == 4'd7) k = C_LWD;
    else if (o == 4'd8) k = C_SWD;
    else if (o == 4'd9) k = C_JMP;
    else if (o == 4'd10) k = C_JAL;
    return k;
  endfunction

  // Per-instruction totals: cycles spent, strobe cycle counts, and
  // the selects seen on register write, EX and jump.
  function automatic exp_t model(logic [3:0] o, logic [5:0] f,
                                 int lif, int lmem, int num);
    exp_t e;
    cls_t k;
    int   acc;
    k = cls(o, f);
    acc = lmem + 1;
    e.cycles = lif + 2; e.req = lif + 1; e.rd = lif + 1;
    e.wr = 0; e.irw = 1; e.pcw = 1; e.pcwc = 0; e.rw = 0;
    e.dst = -1; e.src = -1; e.op = 0; e.ex_op = 15;
    e.ex_b = -1; e.jsrc = -1; e.num = num % (1 << NW);
    case (k)
      C_RALU: begin
        e.cycles += 2; e.ex_op = int'(f[3:0]); e.ex_b = 0;
        e.rw = 1; e.dst = 1; e.src = 0;
      end
      C_ADI, C_ORI, C_LHI: begin
        e.cycles += 2; e.ex_b = 2;
        e.ex_op = (k == C_ADI) ? 0 : (k == C_ORI) ? 3 : 8;
        e.rw = 1; e.dst = 0; e.src = 0;
      end
      C_LWD: begin
        e.cycles += 2 + acc; e.req += acc; e.rd += acc;
        e.ex_op = 0; e.ex_b = 2; e.rw = 1; e.dst = 0; e.src = 1;
      end
      C_SWD: begin
        e.cycles += 1 + acc; e.req += acc; e.wr = acc;
        e.ex_op = 0; e.ex_b = 2;
      end
      C_BR: begin
        e.cycles += 1; e.pcwc = 1; e.ex_op = 9 + int'(o); e.ex_b = 0;
      end
      C_JMP: begin e.pcw = 2; e.jsrc = 2; end
      C_JAL: begin
        e.pcw = 2; e.jsrc = 2; e.rw = 1; e.dst = 2; e.src = 2;
      end
      C_JPR: begin e.pcw = 2; e.jsrc = 3; end
      C_JRL: begin
        e.pcw = 2; e.jsrc = 3; e.rw = 1; e.dst = 2; e.src = 2;
      end
      C_WWD: e.op = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(logic [3:0] o, logic [5:0] f,
                       int lif, int lmem, bit retire);
    cls_t k;
    k = cls(o, f);
    instr_q.push_back({o, f});
    lat_q.push_back(lif);
    if (k == C_LWD || k == C_SWD) lat_q.push_back(lmem);
    if (retire) exp_q.push_back(model(o, f, lif, lmem, issued));
    issued++;
  endtask

  task automatic issue_rand();
    int r, lif, lmem;
    logic [3:0] o;
    logic [5:0] f;
    r = $urandom_range(0, 12);
    o = 4'd15;
    f = 6'($urandom_range(0, 63));
    case (r)
      0: f = 6'($urandom_range(0, 7));
      1: o = 4'd4;
      2: o = 4'd5;
      3: o = 4'd6;
      4: o = 4'd7;
      5: o = 4'd8;
      6: o = 4'($urandom_range(0, 3));
      7: o = 4'd9;
      8: o = 4'd10;
      9: f = 6'd25;
      10: f = 6'd26;
      11: f = 6'd28;
      default: o = 4'($urandom_range(11, 14));
    endcase
    lif  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4);
    lmem = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 4);
    issue(o, f, lif, lmem, 1'b1);
  endtask

  task automatic clr_acc();
    a_cyc = 0; a_req = 0; a_rd = 0; a_wr = 0; a_irw = 0;
    a_pcw = 0; a_pcwc = 0; a_rw = 0; a_dst = -1; a_src = -1;
    a_op = 0; a_ex_op = 15; a_ex_b = -1; a_jsrc = -1;
  endtask

  task automatic start_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    exp_q.delete(); instr_q.delete(); lat_q.delete();
    issued = 0;
  endtask

  task automatic end_reset();
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  task automatic wait_drain(string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) begin
      @(negedge clk); #3;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d retires outstanding, expected 0",
               name, exp_q.size());
    end
  endtask

  // Memory and IR model: serves each access after its planned latency.
  initial begin : drv
    int lat, waited;
    bit active, d_req, d_rdy, d_irw, d_rst;
    active = 0; waited = 0; lat = 0;
    mem_ready = 1'b0; opcode = 4'd15; func = 6'd0;
    forever begin
      @(negedge clk);
      if (mem_req && !active) begin
        active = 1; waited = 0;
        lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
      end
      if (mem_req) mem_ready = (waited == lat);
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      d_req = mem_req; d_rdy = mem_ready;
      d_irw = ir_write; d_rst = reset;
      @(posedge clk); #1;
      if (d_rst) begin
        active = 0;
      end else begin
        if (d_req) begin
          if (d_rdy) active = 0;
          else waited++;
        end
        if (d_irw) begin
          if (instr_q.size() != 0) {opcode, func} = instr_q.pop_front();
          else {opcode, func} = {4'd15, 6'd29};
        end
      end
    end
  end

  initial begin : mon
    exp_t e;
    clr_acc();
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        clr_acc();
      end else begin
        a_cyc++;
        if (mem_req) a_req++;
        if (read_m) a_rd++;
        if (write_m) a_wr++;
        if (ir_write) a_irw++;
        if (pc_write) a_pcw++;
        if (pc_write_cond) a_pcwc++;
        if (open_port) a_op++;
        if (reg_write) begin
          a_rw++; a_dst = int'(reg_dst); a_src = int'(reg_src);
        end
        if (alu_src_a) begin
          a_ex_op = int'(alu_op); a_ex_b = int'(alu_src_b);
        end
        if (pc_write && !ir_write) a_jsrc = int'(pc_src);
        if (inst_done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_retire: got retire, expected none");
          end else begin
            e = exp_q.pop_front();
            chk("cycles", a_cyc, e.cycles);
            chk("mem_req_cycles", a_req, e.req);
            chk("read_m_cycles", a_rd, e.rd);
            chk("write_m_cycles", a_wr, e.wr);
            chk("ir_write_cycles", a_irw, e.irw);
            chk("pc_write_cycles", a_pcw, e.pcw);
            chk("pc_write_cond_cycles", a_pcwc, e.pcwc);
            chk("reg_write_cycles", a_rw, e.rw);
            chk("reg_dst", a_dst, e.dst);
            chk("reg_src", a_src, e.src);
            chk("open_port_cycles", a_op, e.op);
            chk("ex_alu_op", a_ex_op, e.ex_op);
            chk("ex_alu_src_b", a_ex_b, e.ex_b);
            chk("jump_pc_src", a_jsrc, e.jsrc);
            chk("num_inst", int'(num_inst), e.num);
          end
          clr_acc();
        end
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_strobes", int'({mem_req, read_m, write_m, iord, ir_write,
        pc_write, pc_write_cond, reg_write, open_port, inst_done}), 0);
    chk("rst_selects", int'({pc_src, reg_dst, reg_src,
        alu_src_a, alu_src_b}), 0);
    chk("rst_alu_op", int'(alu_op), 15);
    chk("rst_num_inst", int'(num_inst), 0);
    chk("rst_flags", int'({halted, mem_error}), 0);

    issue(4'd15, 6'd0, 0, 0, 1'b1);
    issue(4'd7, 6'($urandom_range(0, 63)), 3, 2, 1'b1);
    issue(4'd1, 6'($urandom_range(0, 63)), 0, 0, 1'b1);
    for (int i = 0; i < 17; i++)
      issue(4'd9, 6'($urandom_range(0, 63)), $urandom_range(0, 2), 0, 1'b1);
    for (int i = 0; i < 50; i++) issue_rand();
    issue(4'd15, 6'd29, 1, 0, 1'b1);
    end_reset();
    wait_drain("program");
    @(negedge clk); #2;
    chk("halted", int'(halted), 1);
    chk("no_mem_error", int'(mem_error), 0);
    chk("final_num_inst", int'(num_inst), issued % (1 << NW));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (mem_req) n++;
    end
    chk("halt_mem_req_cycles", n, 0);
    chk("halt_num_frozen", int'(num_inst), issued % (1 << NW));

    start_reset();
    lat_q.push_back(1000);
    end_reset();
    n = 0;
    for (int i = 0; i < 40 && !mem_error; i++) begin
      @(negedge clk); #2;
      if (mem_req) n++;
    end
    chk("watchdog_wait_cycles", n, 15);
    chk("watchdog_mem_error", int'(mem_error), 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      if (mem_req || !mem_error) n++;
    end
    chk("err_sticky_idle", n, 0);
    chk("err_num_inst", int'(num_inst), 0);

    start_reset();
    issue(4'd7, 6'($urandom_range(0, 63)), 14, 14, 1'b1);
    issue(4'd15, 6'd29, 0, 0, 1'b1);
    end_reset();
    wait_drain("limit_ready");
    @(negedge clk); #2;
    chk("limit_ready_no_error", int'(mem_error), 0);
    chk("limit_ready_halted", int'(halted), 1);

    start_reset();
    issue(4'd8, 6'($urandom_range(0, 63)), 0, 1000, 1'b0);
    end_reset();
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk); #2;
      if (write_m) n++;
    end
    chk("swd_wait_seen", n, 3);
    start_reset();
    issue(4'd15, 6'd29, 0, 0, 1'b1);
    @(negedge clk); #2;
    chk("reset_abort_req", int'({mem_req, write_m}), 0);
    end_reset();
    @(negedge clk); #2;
    chk("post_reset_fetch", int'({mem_req, read_m, write_m, iord}), 12);
    chk("post_reset_num_inst", int'(num_inst), 0);
    wait_drain("post_reset");
    @(negedge clk); #2;
    chk("post_reset_halted", int'(halted), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
